// File: rtl/mac_ram_readout_pkg.sv
// Shared constants and sequencer state encoding for the MAC bank readout path.
package mac_ram_readout_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAITMAC,
    ST_OPEN,
    ST_READ,
    ST_DRAIN,
    ST_CLRGAP,
    ST_CLR,
    ST_CLRWAIT
  } state_e;

  function automatic logic is_clearing(input state_e s);
    return (s == ST_CLRGAP) || (s == ST_CLR) || (s == ST_CLRWAIT);
  endfunction
endpackage

// File: rtl/mac_ram_readout_fifo.sv
// Show-ahead sync FIFO holding captured words with their lag index and last flag.
module readout_fifo
  import mac_ram_readout_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic              wr_last,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  rd_index,
  output logic              rd_last,
  output logic              empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  index;
    logic              last;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  entry_t           head;

  assign push = wr_en && (count_q != CNT_W'(DEPTH));
  assign pop  = rd_en && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{data: wr_data, index: wr_index, last: wr_last};
  end

  // Stale storage is masked so the stream outputs read zero whenever nothing is queued.
  assign empty    = (count_q == '0);
  assign head     = empty ? '0 : mem_q[rd_ptr_q];
  assign rd_data  = head.data;
  assign rd_index = head.index;
  assign rd_last  = head.last;
  assign count    = count_q;
endmodule

// File: rtl/mac_ram_readout.sv
// Readout sequencer for one RAM-based MAC bank: waits out bursts, sweeps all lags into a
// credit-checked FIFO, streams them on valid/ready, then optionally clears the bank.
module mac_ram_readout
  import mac_ram_readout_pkg::*;
#(
  parameter int WIDTHofADDR = ADDR_W_DEF,
  parameter int RD_LAT      = RD_LAT_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter bit CLR_AFTER   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sin,
  output logic                   read,
  output logic [WIDTHofADDR-1:0] rAddr,
  output logic                   clr,
  input  logic [DATA_W-1:0]      rData,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [WIDTHofADDR-1:0] out_index,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   lost
);
  localparam int              W        = WIDTHofADDR;
  localparam int              CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int              CRED_W   = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
  localparam logic [W-1:0]    TOP_ADDR = {W{1'b1}};
  localparam logic [W:0]      BANK_LEN = {1'b1, {W{1'b0}}};

  state_e            state_q, state_d;
  logic              read_q, read_d, issue_q, issue_d;
  logic              clr_q, clr_d, busy_q, busy_d, done_q, done_d, lost_q, lost_d;
  logic [W-1:0]      raddr_q, raddr_d, next_addr_q, next_addr_d;
  logic [W:0]        burst_q, burst_d, wait_q, wait_d;
  logic [RD_LAT-1:0] pipe_v_q, pipe_v_d;
  logic [W-1:0]      pipe_idx_q [RD_LAT];
  logic [W-1:0]      pipe_idx_d [RD_LAT];
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, clearing, can_issue;
  logic [CRED_W-1:0] in_flight;

  // Valid/index pipe tracks each issued address until its data appears on rData.
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      assign pipe_v_d[gi]   = issue_q;
      assign pipe_idx_d[gi] = raddr_q;
    end else begin : g_tail
      assign pipe_v_d[gi]   = pipe_v_q[gi-1];
      assign pipe_idx_d[gi] = pipe_idx_q[gi-1];
    end
  end

  // Issue only when every outstanding read plus the new one is guaranteed a FIFO slot.
  always_comb begin
    in_flight = CRED_W'(issue_q);
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CRED_W'(pipe_v_q[i]);
    can_issue = (in_flight + CRED_W'(fifo_count)) < CRED_W'(FIFO_DEPTH);
  end

  assign clearing = is_clearing(state_q);

  always_comb begin
    state_d     = state_q;
    read_d      = read_q;
    raddr_d     = raddr_q;
    next_addr_d = next_addr_q;
    issue_d     = 1'b0;
    clr_d       = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    lost_d      = lost_q;
    wait_d      = wait_q;
    burst_d     = (burst_q != '0) ? burst_q - 1'b1 : burst_q;
    if (sin) begin
      if (read_q || clearing) lost_d  = 1'b1;
      else                    burst_d = BANK_LEN;
    end
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_WAITMAC;
        busy_d  = 1'b1;
        lost_d  = 1'b0;
      end
      ST_WAITMAC: if (burst_q == '0 && !sin) begin
        state_d     = ST_OPEN;
        read_d      = 1'b1;
        raddr_d     = '0;
        next_addr_d = '0;
      end
      ST_OPEN, ST_READ: begin
        if (state_q == ST_OPEN) state_d = ST_READ;
        if (can_issue) begin
          issue_d     = 1'b1;
          raddr_d     = next_addr_q;
          next_addr_d = next_addr_q + 1'b1;
          if (next_addr_q == TOP_ADDR) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (read_q) begin
          if (in_flight == '0) read_d = 1'b0;
        end else if (fifo_empty) begin
          if (CLR_AFTER) begin
            state_d = ST_CLRGAP;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_CLRGAP: begin
        state_d = ST_CLR;
        clr_d   = 1'b1;
      end
      ST_CLR: begin
        state_d = ST_CLRWAIT;
        wait_d  = BANK_LEN;
      end
      ST_CLRWAIT: begin
        if (wait_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      read_q      <= 1'b0;
      raddr_q     <= '0;
      next_addr_q <= '0;
      issue_q     <= 1'b0;
      clr_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lost_q      <= 1'b0;
      burst_q     <= '0;
      wait_q      <= '0;
      pipe_v_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_idx_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      raddr_q     <= raddr_d;
      next_addr_q <= next_addr_d;
      issue_q     <= issue_d;
      clr_q       <= clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lost_q      <= lost_d;
      burst_q     <= burst_d;
      wait_q      <= wait_d;
      pipe_v_q    <= pipe_v_d;
      for (int i = 0; i < RD_LAT; i++) pipe_idx_q[i] <= pipe_idx_d[i];
    end
  end

  readout_fifo #(.DEPTH(FIFO_DEPTH), .IDX_W(W)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (pipe_v_q[RD_LAT-1]),
    .wr_data  (rData),
    .wr_index (pipe_idx_q[RD_LAT-1]),
    .wr_last  (pipe_idx_q[RD_LAT-1] == TOP_ADDR),
    .rd_en    (out_valid && out_ready),
    .rd_data  (out_data),
    .rd_index (out_index),
    .rd_last  (out_last),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign read      = read_q;
  assign rAddr     = raddr_q;
  assign clr       = clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lost      = lost_q;
endmodule

// File: tb/tb_mac_ram_readout.sv
// Scoreboard bench: a behavioural MAC bank feeds rData; a monitor checks every streamed word.
module tb_mac_ram_readout;
  localparam int W = 5;
  localparam int N = 32;

  typedef struct packed {
    logic [31:0]  data;
    logic [W-1:0] index;
    logic         last;
  } word_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sin = 1'b0, out_ready = 1'b0;
  logic read, clr, out_valid, out_last, busy, done, lost;
  logic [W-1:0] rAddr, out_index;
  logic [31:0]  rData, out_data;

  always #5 clk = ~clk;

  mac_ram_readout #(.WIDTHofADDR(W), .RD_LAT(2), .FIFO_DEPTH(4), .CLR_AFTER(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sin(sin), .read(read), .rAddr(rAddr),
    .clr(clr), .rData(rData), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done), .lost(lost)
  );

  // Bank model: two-cycle read latency, garbage when read is low, clear on clr.
  logic [31:0] bank [N];
  logic [31:0] bp0, bp1;
  logic        load_req = 1'b0;
  always @(posedge clk) begin
    bp0 <= read ? bank[rAddr] : 32'hDEADBEEF;
    bp1 <= bp0;
    if (clr) for (int k = 0; k < N; k++) bank[k] <= '0;
    else if (load_req) for (int k = 0; k < N; k++) bank[k] <= 32'(k * 3);
  end
  assign rData = bp1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  word_t sb[$];
  int    checks = 0, errors = 0;
  int    rx_cnt = 0, read_rises = 0, clr_pulses = 0, read_rise_cyc = 0, clr_cyc = 0, sin_cyc = 0;
  bit    ready_rand = 1'b0, ready_fix = 1'b1;
  logic  prev_read = 1'b0, prev_clr = 1'b0, prev_hold = 1'b0;
  word_t got_w, exp_w, held_w;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_read = 1'b0;
        prev_clr  = 1'b0;
        prev_hold = 1'b0;
      end else begin
        got_w = {out_data, out_index, out_last};
        if (prev_hold) begin
          checks++;
          if (!out_valid || got_w !== held_w) begin
            errors++;
            $display("FAIL hold_stable: got valid=%0b word=%h expected valid=1 word=%h",
                     out_valid, got_w, held_w);
          end
        end
        if (read && !prev_read) begin
          read_rises++;
          read_rise_cyc = cyc;
        end
        if (clr) begin
          checks++;
          clr_pulses++;
          clr_cyc = cyc;
          if (prev_read || prev_clr) begin
            errors++;
            $display("FAIL clr_gap: got prev_read=%0b prev_clr=%0b expected both 0",
                     prev_read, prev_clr);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got idx=%0d data=%0h expected no word",
                     out_index, out_data);
          end else begin
            exp_w = sb.pop_front();
            if (got_w !== exp_w) begin
              errors++;
              $display("FAIL word: got data=%0h idx=%0d last=%0b expected data=%0h idx=%0d last=%0b",
                       got_w.data, got_w.index, got_w.last, exp_w.data, exp_w.index, exp_w.last);
            end
          end
          rx_cnt++;
        end
        prev_hold = out_valid && !out_ready;
        held_w    = got_w;
        prev_read = read;
        prev_clr  = clr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic load_bank();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic begin_dump(input bit zeros);
    for (int k = 0; k < N; k++) sb.push_back({zeros ? 32'd0 : 32'(k * 3), W'(k), k == N - 1});
    rx_cnt = 0; read_rises = 0; clr_pulses = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 64'(busy), 64'd1);
    check("lost_cleared_by_start", 64'(lost), 64'd0);
  endtask

  task automatic wait_rx(input int n);
    for (int t = 0; t < 3000 && rx_cnt < n; t++) @(negedge clk);
    check("wait_rx_in_time", 64'(rx_cnt >= n), 64'd1);
  endtask

  task automatic finish_dump(input string tag);
    bit seen = 1'b0;
    int done_cyc = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
    check({tag, "_word_count"}, 64'(rx_cnt), 64'(N));
    check({tag, "_scoreboard_empty"}, 64'(sb.size()), 64'd0);
    check({tag, "_read_rises"}, 64'(read_rises), 64'd1);
    check({tag, "_clr_pulses"}, 64'(clr_pulses), 64'd1);
    check({tag, "_clr_to_done"}, 64'(done_cyc - clr_cyc), 64'(N + 2));
    @(negedge clk);
    check({tag, "_done_single"}, 64'(done), 64'd0);
    sb.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", 64'({read, rAddr, clr, out_valid, out_data, out_index, out_last,
                                busy, done, lost}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Plain dump of k*3 with a ready consumer.
    load_bank();
    begin_dump(1'b0);
    finish_dump("basic");
    check("basic_lost", 64'(lost), 64'd0);

    // The previous dump cleared the bank.
    tick();
    begin_dump(1'b1);
    finish_dump("cleared");

    // Burst in progress three cycles before start.
    load_bank();
    sin = 1'b1;
    sin_cyc = cyc;
    tick();
    sin = 1'b0;
    tick();
    tick();
    begin_dump(1'b0);
    finish_dump("burst_wait");
    check("burst_wait_read_delay", 64'(read_rise_cyc - sin_cyc >= 33), 64'd1);
    check("burst_wait_lost", 64'(lost), 64'd0);

    // Random backpressure plus a start pulse that must be ignored.
    load_bank();
    ready_rand = 1'b1;
    begin_dump(1'b0);
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_dump("backpressure");
    ready_rand = 1'b0;

    // Sample strobe while the bank is held in read.
    tick();
    load_bank();
    begin_dump(1'b0);
    wait_rx(5);
    tick();
    check("read_high_mid_dump", 64'(read), 64'd1);
    sin = 1'b1;
    tick();
    sin = 1'b0;
    @(negedge clk);
    check("lost_set", 64'(lost), 64'd1);
    finish_dump("lost");
    check("lost_sticky_at_done", 64'(lost), 64'd1);

    // Reset in the middle of a dump.
    tick();
    load_bank();
    begin_dump(1'b0);
    wait_rx(10);
    tick();
    rst_n = 1'b0;
    sb.delete();
    tick();
    @(negedge clk);
    check("midreset_outputs", 64'({read, rAddr, clr, out_valid, out_data, out_index, out_last,
                                   busy, done, lost}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fresh dump after the abort.
    load_bank();
    begin_dump(1'b0);
    finish_dump("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
